// File: rtl/poly_voice_mixer_if.sv
// Bundle of sequencer, voice and codec signals around the voice mixer.
// Latency: none, wires only.
// Backpressure: none; strobes are single-cycle and never stalled.
interface poly_voice_mixer_if #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 6,
   parameter int SAMPLE_W   = 16,
   parameter int SUM_W      = 18
);
   // sequencer / voice / codec side inputs to the mixer
   logic                           play_enable;
   logic                           beat;
   logic                           load_new_note;
   logic [NOTE_W-1:0]              note_to_load;
   logic [DUR_W-1:0]               duration;
   logic                           release_all;
   logic                           generate_next_sample;
   logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample;
   logic [NUM_VOICES-1:0]          voice_sample_ready;
   // mixer outputs
   logic [NUM_VOICES-1:0]          voice_load;
   logic [NUM_VOICES*NOTE_W-1:0]   voice_note;
   logic [NUM_VOICES-1:0]          voice_active;
   logic                           note_accepted;
   logic                           note_stolen;
   logic                           all_done;
   logic [SUM_W-1:0]               final_sample;
   logic                           sample_ready;

   modport master (
      output play_enable, beat, load_new_note, note_to_load, duration, release_all,
             generate_next_sample, voice_sample, voice_sample_ready,
      input  voice_load, voice_note, voice_active, note_accepted, note_stolen,
             all_done, final_sample, sample_ready
   );

   modport slave (
      input  play_enable, beat, load_new_note, note_to_load, duration, release_all,
             generate_next_sample, voice_sample, voice_sample_ready,
      output voice_load, voice_note, voice_active, note_accepted, note_stolen,
             all_done, final_sample, sample_ready
   );
endinterface

// File: rtl/poly_voice_mixer.sv
// N-voice note allocator with per-voice beat countdown and a saturating sample mixer.
// Latency: load pulses 1 cycle after request; sample_ready 1 cycle after the last needed voice ready.
// Backpressure: none; requests are ignored while play_enable=0, notes dropped when full and stealing is off.
module poly_voice_mixer #(
   parameter int NUM_VOICES = 4,
   parameter int NOTE_W     = 6,
   parameter int DUR_W      = 6,
   parameter int SAMPLE_W   = 16,
   parameter int SUM_W      = 18,
   parameter bit STEAL_EN   = 1'b1
) (
   input logic                clk,
   input logic                reset,
   poly_voice_mixer_if.slave  bus
);
   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   // accumulator is wide enough for 16 full-scale voices and strictly wider than SUM_W
   localparam int ACC_W = (SUM_W > SAMPLE_W + 4) ? SUM_W + 1 : SAMPLE_W + 5;
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-SUM_W+1){1'b0}}, {(SUM_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-SUM_W+1){1'b1}}, {(SUM_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

   // voice allocation state
   logic [DUR_W-1:0]      count_q [NUM_VOICES];
   logic [DUR_W-1:0]      count_d [NUM_VOICES];
   logic [NOTE_W-1:0]     note_q  [NUM_VOICES];
   logic [NOTE_W-1:0]     note_d  [NUM_VOICES];
   logic [NUM_VOICES-1:0] load_q, load_d;
   logic                  accepted_q, accepted_d;
   logic                  stolen_q, stolen_d;
   logic [NUM_VOICES-1:0] active;

   logic                  free_found;
   logic [IDX_W-1:0]      free_idx, min_idx, tgt_idx;
   logic [DUR_W-1:0]      min_cnt;
   logic                  load_req, do_load;

   // mixer state
   state_t                state_q, state_d;
   logic [NUM_VOICES-1:0] got_q, got_d;
   logic [SAMPLE_W-1:0]   hold_q [NUM_VOICES];
   logic [SAMPLE_W-1:0]   hold_d [NUM_VOICES];
   logic [SUM_W-1:0]      final_q, final_d;
   logic                  sready_q, sready_d;
   logic signed [ACC_W-1:0] acc;
   logic [SUM_W-1:0]      mix_sat;
   logic                  collect_done;

   // per-voice busy flags and the packed note bus
   always_comb begin
      active = '0;
      bus.voice_note = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         active[i] = (count_q[i] != '0);
         bus.voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
      end
   end

   // find lowest free voice and the voice closest to expiry (lowest index on ties)
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      min_idx    = '0;
      min_cnt    = count_q[0];
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (!free_found && count_q[i] == '0) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if (count_q[i] < min_cnt) begin
            min_cnt = count_q[i];
            min_idx = IDX_W'(i);
         end
      end
   end

   // release_all outranks a load; a zero-length note never allocates
   assign load_req = bus.load_new_note && bus.play_enable && (bus.duration != '0) && !bus.release_all;
   assign do_load  = load_req && (free_found || STEAL_EN);
   assign tgt_idx  = free_found ? free_idx : min_idx;

   // counter / note next state: release > load > beat; the loaded voice skips this beat
   always_comb begin
      load_d     = '0;
      accepted_d = do_load;
      stolen_d   = do_load && !free_found;
      for (int i = 0; i < NUM_VOICES; i++) begin
         count_d[i] = count_q[i];
         note_d[i]  = note_q[i];
         if (bus.release_all) begin
            count_d[i] = '0;
         end else if (do_load && tgt_idx == IDX_W'(i)) begin
            count_d[i] = bus.duration;
            note_d[i]  = bus.note_to_load;
            load_d[i]  = 1'b1;
         end else if (bus.beat && bus.play_enable && count_q[i] != '0) begin
            count_d[i] = count_q[i] - DUR_W'(1);
         end
      end
   end

   // allocation registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            count_q[i] <= '0;
            note_q[i]  <= '0;
         end
         load_q     <= '0;
         accepted_q <= 1'b0;
         stolen_q   <= 1'b0;
      end else begin
         count_q    <= count_d;
         note_q     <= note_d;
         load_q     <= load_d;
         accepted_q <= accepted_d;
         stolen_q   <= stolen_d;
      end
   end

   // capture samples on any ready; a ready on the EMIT->IDLE edge survives the clear
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         hold_d[i] = bus.voice_sample_ready[i] ? bus.voice_sample[i*SAMPLE_W +: SAMPLE_W] : hold_q[i];
      end
      got_d = (state_q == S_EMIT) ? bus.voice_sample_ready : (got_q | bus.voice_sample_ready);
   end

   assign collect_done = &(got_q | bus.voice_sample_ready | ~active);

   // sum the active voices' newest samples and clamp to the output range
   always_comb begin
      acc = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (active[i]) begin
            acc = acc + ACC_W'($signed(hold_d[i]));
         end
      end
      if (acc > SAT_MAX) begin
         mix_sat = SAT_MAX[SUM_W-1:0];
      end else if (acc < SAT_MIN) begin
         mix_sat = SAT_MIN[SUM_W-1:0];
      end else begin
         mix_sat = acc[SUM_W-1:0];
      end
   end

   // mixer FSM next state; the mix is latched on entry to EMIT so ready follows the last sample by one cycle
   always_comb begin
      state_d  = state_q;
      final_d  = final_q;
      sready_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.generate_next_sample && bus.play_enable) begin
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (bus.play_enable && collect_done) begin
               state_d  = S_EMIT;
               final_d  = mix_sat;
               sready_d = 1'b1;
            end
         end
         S_EMIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // mixer state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // mixer datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         got_q    <= '0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            hold_q[i] <= '0;
         end
         final_q  <= '0;
         sready_q <= 1'b0;
      end else begin
         got_q    <= got_d;
         hold_q   <= hold_d;
         final_q  <= final_d;
         sready_q <= sready_d;
      end
   end

   assign bus.voice_load    = load_q;
   assign bus.voice_active  = active;
   assign bus.note_accepted = accepted_q;
   assign bus.note_stolen   = stolen_q;
   assign bus.all_done      = ~|active;
   assign bus.final_sample  = final_q;
   assign bus.sample_ready  = sready_q;
endmodule

// File: tb/tb_poly_voice_mixer.sv
// Bench for poly_voice_mixer: two instances (steal + 18-bit mix, drop + 17-bit mix) share stimulus.
// Every cycle both are compared against a spec-level model; directed sequences and a mix table add fixed expectations.
module tb_poly_voice_mixer;
   localparam int NV = 4;
   localparam int NW = 6;
   localparam int DW = 6;
   localparam int SW = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic              play_enable, beat, load_new_note, release_all, generate_next_sample;
   logic [NW-1:0]     note_to_load;
   logic [DW-1:0]     duration;
   logic [NV*SW-1:0]  voice_sample;
   logic [NV-1:0]     voice_sample_ready;

   poly_voice_mixer_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .SAMPLE_W(SW), .SUM_W(18)) ifa ();
   poly_voice_mixer_if #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .SAMPLE_W(SW), .SUM_W(17)) ifb ();

   assign ifa.play_enable = play_enable;           assign ifb.play_enable = play_enable;
   assign ifa.beat = beat;                         assign ifb.beat = beat;
   assign ifa.load_new_note = load_new_note;       assign ifb.load_new_note = load_new_note;
   assign ifa.note_to_load = note_to_load;         assign ifb.note_to_load = note_to_load;
   assign ifa.duration = duration;                 assign ifb.duration = duration;
   assign ifa.release_all = release_all;           assign ifb.release_all = release_all;
   assign ifa.generate_next_sample = generate_next_sample;
   assign ifb.generate_next_sample = generate_next_sample;
   assign ifa.voice_sample = voice_sample;         assign ifb.voice_sample = voice_sample;
   assign ifa.voice_sample_ready = voice_sample_ready;
   assign ifb.voice_sample_ready = voice_sample_ready;

   poly_voice_mixer #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .SAMPLE_W(SW), .SUM_W(18), .STEAL_EN(1'b1))
      dut_a (.clk(clk), .reset(reset), .bus(ifa));
   poly_voice_mixer #(.NUM_VOICES(NV), .NOTE_W(NW), .DUR_W(DW), .SAMPLE_W(SW), .SUM_W(17), .STEAL_EN(1'b0))
      dut_b (.clk(clk), .reset(reset), .bus(ifb));

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state, index 0 = dut_a, 1 = dut_b
   int m_cnt  [2][NV];
   int m_note [2][NV];
   int m_held [2][NV];
   int m_got  [2][NV];
   int m_load [2];
   int m_acc  [2];
   int m_stl  [2];
   int m_fs   [2];
   int m_sr   [2];
   int m_wait [2];
   int m_emit [2];
   int m_steal[2];
   int m_sumw [2];

   typedef struct {
      logic [NV*SW-1:0] smp;
      int               exp_a;
      int               exp_b;
   } mix_vec_t;
   mix_vec_t tbl[9];

   task automatic chk(string name, logic signed [63:0] act, logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [NV*SW-1:0] pk(int s0, int s1, int s2, int s3);
      return {SW'(s3), SW'(s2), SW'(s1), SW'(s0)};
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         for (int v = 0; v < NV; v++) begin
            m_cnt[m][v] = 0; m_note[m][v] = 0; m_held[m][v] = 0; m_got[m][v] = 0;
         end
         m_load[m] = 0; m_acc[m] = 0; m_stl[m] = 0; m_fs[m] = 0; m_sr[m] = 0;
         m_wait[m] = 0; m_emit[m] = 0;
      end
   endtask

   // advance model m by one clock using the inputs currently applied
   task automatic model_step(int m);
      int     act[NV];
      int     tgt, stolen, all_ok;
      longint sum, lim;
      for (int v = 0; v < NV; v++) act[v] = (m_cnt[m][v] != 0);
      m_sr[m] = 0;
      for (int v = 0; v < NV; v++)
         if (voice_sample_ready[v]) m_held[m][v] = int'($signed(voice_sample[v*SW +: SW]));
      if (m_emit[m] != 0) begin
         m_emit[m] = 0;
         for (int v = 0; v < NV; v++) m_got[m][v] = int'(voice_sample_ready[v]);
      end else begin
         for (int v = 0; v < NV; v++) if (voice_sample_ready[v]) m_got[m][v] = 1;
         if (m_wait[m] != 0) begin
            if (play_enable) begin
               all_ok = 1;
               for (int v = 0; v < NV; v++) if (act[v] != 0 && m_got[m][v] == 0) all_ok = 0;
               if (all_ok != 0) begin
                  sum = 0;
                  for (int v = 0; v < NV; v++) if (act[v] != 0) sum += m_held[m][v];
                  lim = longint'(1) <<< (m_sumw[m] - 1);
                  if (sum > lim - 1) sum = lim - 1;
                  if (sum < -lim) sum = -lim;
                  m_fs[m] = int'(sum);
                  m_sr[m] = 1; m_wait[m] = 0; m_emit[m] = 1;
               end
            end
         end else if (generate_next_sample && play_enable) begin
            m_wait[m] = 1;
         end
      end
      m_load[m] = 0; m_acc[m] = 0; m_stl[m] = 0;
      if (release_all) begin
         for (int v = 0; v < NV; v++) m_cnt[m][v] = 0;
      end else begin
         tgt = -1; stolen = 0;
         if (load_new_note && play_enable && duration != 0) begin
            for (int v = 0; v < NV; v++) if (tgt < 0 && m_cnt[m][v] == 0) tgt = v;
            if (tgt < 0 && m_steal[m] != 0) begin
               tgt = 0;
               for (int v = 1; v < NV; v++) if (m_cnt[m][v] < m_cnt[m][tgt]) tgt = v;
               stolen = 1;
            end
         end
         if (beat && play_enable)
            for (int v = 0; v < NV; v++) if (v != tgt && m_cnt[m][v] > 0) m_cnt[m][v]--;
         if (tgt >= 0) begin
            m_cnt[m][tgt]  = int'(duration);
            m_note[m][tgt] = int'(note_to_load);
            m_load[m] = 1 << tgt; m_acc[m] = 1; m_stl[m] = stolen;
         end
      end
   endtask

   task automatic check_model(int m, logic [NV-1:0] vl, logic [NV*NW-1:0] vn, logic [NV-1:0] va,
                              logic na, logic ns, logic ad, logic signed [63:0] fs, logic sr);
      logic [NV*NW-1:0] en;
      logic [NV-1:0]    ea;
      for (int v = 0; v < NV; v++) begin
         en[v*NW +: NW] = NW'(m_note[m][v]);
         ea[v] = (m_cnt[m][v] != 0);
      end
      chk($sformatf("dut%0d_voice_load", m), vl, m_load[m]);
      chk($sformatf("dut%0d_voice_note", m), vn, en);
      chk($sformatf("dut%0d_voice_active", m), va, ea);
      chk($sformatf("dut%0d_note_accepted", m), na, m_acc[m]);
      chk($sformatf("dut%0d_note_stolen", m), ns, m_stl[m]);
      chk($sformatf("dut%0d_all_done", m), ad, (ea == '0));
      chk($sformatf("dut%0d_final_sample", m), fs, m_fs[m]);
      chk($sformatf("dut%0d_sample_ready", m), sr, m_sr[m]);
   endtask

   task automatic step();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_model(0, ifa.voice_load, ifa.voice_note, ifa.voice_active, ifa.note_accepted,
                  ifa.note_stolen, ifa.all_done, $signed(ifa.final_sample), ifa.sample_ready);
      check_model(1, ifb.voice_load, ifb.voice_note, ifb.voice_active, ifb.note_accepted,
                  ifb.note_stolen, ifb.all_done, $signed(ifb.final_sample), ifb.sample_ready);
   endtask

   task automatic clear_inputs();
      play_enable = 1'b1; beat = 1'b0; load_new_note = 1'b0; release_all = 1'b0;
      generate_next_sample = 1'b0; note_to_load = '0; duration = '0;
      voice_sample = '0; voice_sample_ready = '0;
   endtask

   task automatic load(int note, int dur);
      load_new_note = 1'b1; note_to_load = NW'(note); duration = DW'(dur);
      step();
      load_new_note = 1'b0;
   endtask

   task automatic release_voices();
      release_all = 1'b1;
      step();
      release_all = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      clear_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_all_done", ifa.all_done, 1);
      chk("rst_voice_active", ifa.voice_active, 0);
      chk("rst_sample_ready", ifa.sample_ready, 0);
      chk("rst_final_sample", $signed(ifa.final_sample), 0);
      chk("rst_voice_load", ifa.voice_load, 0);
      chk("rst_note_accepted", ifa.note_accepted, 0);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      m_steal[0] = 1; m_steal[1] = 0;
      m_sumw[0]  = 18; m_sumw[1] = 17;
      tbl[0] = '{pk( 30000,  30000,  30000,  30000),  120000,  65535};
      tbl[1] = '{pk(-30000, -30000, -30000, -30000), -120000, -65536};
      tbl[2] = '{pk( 32767,  32767,  32767,  32767),  131068,  65535};
      tbl[3] = '{pk(-32768, -32768, -32768, -32768), -131072, -65536};
      tbl[4] = '{pk(  1000,   -300,      0,      0),     700,    700};
      tbl[5] = '{pk( 16384,  16384,  16384,  16384),   65536,  65535};
      tbl[6] = '{pk( 16383,  16384,  16384,  16384),   65535,  65535};
      tbl[7] = '{pk(-16384, -16384, -16384, -16384),  -65536, -65536};
      tbl[8] = '{pk(-16384, -16384, -16384, -16385),  -65537, -65536};

      // first three notes go to voices 0,1,2 in order
      do_reset();
      load(10, 5); chk("t1_load_v0", ifa.voice_load, 4'b0001);
      load(20, 5); chk("t1_load_v1", ifa.voice_load, 4'b0010);
      load(30, 5); chk("t1_load_v2", ifa.voice_load, 4'b0100);
      chk("t1_active", ifa.voice_active, 4'b0111);
      chk("t1_note2", ifa.voice_note[2*NW +: NW], 30);
      chk("t1_all_done", ifa.all_done, 0);

      // all busy: steal the shortest remaining (voice 1) or drop
      release_voices();
      load(1, 8); load(2, 3); load(3, 6); load(4, 9);
      load(40, 4);
      chk("t2_steal_acc", ifa.note_accepted, 1);
      chk("t2_steal_flag", ifa.note_stolen, 1);
      chk("t2_steal_load", ifa.voice_load, 4'b0010);
      chk("t2_steal_note", ifa.voice_note[1*NW +: NW], 40);
      chk("t2_drop_acc", ifb.note_accepted, 0);
      chk("t2_drop_load", ifb.voice_load, 0);
      chk("t2_drop_note", ifb.voice_note[1*NW +: NW], 2);
      beat = 1'b1;
      repeat (3) step();
      chk("t2_steal_cnt3", ifa.voice_active[1], 1);
      step();
      beat = 1'b0;
      chk("t2_steal_cnt4", ifa.voice_active, 4'b1101);
      chk("t2_drop_cnt", ifb.voice_active, 4'b1101);

      // zero duration, countdown expiry, beat with load, release with load
      release_voices();
      load(5, 0);
      chk("t3_dur0_acc", ifa.note_accepted, 0);
      chk("t3_dur0_load", ifa.voice_load, 0);
      load(5, 2);
      beat = 1'b1; step();
      chk("t3_beat1_active", ifa.voice_active[0], 1);
      step();
      chk("t3_beat2_active", ifa.voice_active[0], 0);
      chk("t3_beat2_done", ifa.all_done, 1);
      beat = 1'b0;
      load(6, 3);
      beat = 1'b1;
      load(7, 5);
      chk("t3_beatload_v1", ifa.voice_load, 4'b0010);
      repeat (2) step();
      chk("t3_other_dec", ifa.voice_active, 4'b0010);
      repeat (2) step();
      chk("t3_full_dur", ifa.voice_active, 4'b0010);
      step();
      chk("t3_expired", ifa.voice_active, 4'b0000);
      beat = 1'b0;
      release_all = 1'b1;
      load(9, 4);
      release_all = 1'b0;
      chk("t3_rel_load", ifa.voice_load, 0);
      chk("t3_rel_acc", ifa.note_accepted, 0);
      chk("t3_rel_done", ifa.all_done, 1);

      // two voices, readies three cycles apart
      load(1, 20); load(2, 20);
      generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
      voice_sample_ready = 4'b0001; voice_sample = pk(1000, 0, 0, 0);
      step();
      voice_sample_ready = '0;
      chk("t4_early_sr", ifa.sample_ready, 0);
      repeat (2) step();
      chk("t4_wait_sr", ifa.sample_ready, 0);
      voice_sample_ready = 4'b0010; voice_sample = pk(0, -300, 0, 0);
      step();
      voice_sample_ready = '0;
      chk("t4_sr_a", ifa.sample_ready, 1);
      chk("t4_fs_a", $signed(ifa.final_sample), 700);
      chk("t4_fs_b", $signed(ifb.final_sample), 700);
      step();
      chk("t4_sr_pulse", ifa.sample_ready, 0);
      // no active voices: ready two cycles after request, mix 0
      release_voices();
      generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
      chk("t4_empty_sr1", ifa.sample_ready, 0);
      step();
      chk("t4_empty_sr2", ifa.sample_ready, 1);
      chk("t4_empty_fs", $signed(ifa.final_sample), 0);
      step();

      // saturation table with four active voices
      load(1, 60); load(2, 60); load(3, 60); load(4, 60);
      for (int t = 0; t < 9; t++) begin
         generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
         voice_sample_ready = 4'b1111; voice_sample = tbl[t].smp;
         step();
         voice_sample_ready = '0;
         chk($sformatf("t5_sr_a_%0d", t), ifa.sample_ready, 1);
         chk($sformatf("t5_sr_b_%0d", t), ifb.sample_ready, 1);
         chk($sformatf("t5_fs_a_%0d", t), $signed(ifa.final_sample), tbl[t].exp_a);
         chk($sformatf("t5_fs_b_%0d", t), $signed(ifb.final_sample), tbl[t].exp_b);
         step();
      end

      // asynchronous reset in the middle of a collection
      release_voices();
      load(1, 30); load(2, 30); load(3, 30);
      generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
      step();
      reset = 1'b0;
      #1;
      chk("t6_active", ifa.voice_active, 0);
      chk("t6_sr", ifa.sample_ready, 0);
      chk("t6_fs_a", $signed(ifa.final_sample), 0);
      chk("t6_fs_b", $signed(ifb.final_sample), 0);
      chk("t6_done", ifa.all_done, 1);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      clear_inputs();
      load(3, 10);
      generate_next_sample = 1'b1; step(); generate_next_sample = 1'b0;
      voice_sample_ready = 4'b0001; voice_sample = pk(123, 0, 0, 0);
      step();
      voice_sample_ready = '0;
      chk("t6_post_sr", ifa.sample_ready, 1);
      chk("t6_post_fs", $signed(ifa.final_sample), 123);
      step();

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         play_enable          = ($urandom_range(0, 9) != 0);
         beat                 = ($urandom_range(0, 3) == 0);
         load_new_note        = ($urandom_range(0, 2) == 0);
         note_to_load         = NW'($urandom);
         duration             = DW'($urandom_range(0, 12));
         release_all          = ($urandom_range(0, 59) == 0);
         generate_next_sample = ($urandom_range(0, 4) == 0);
         voice_sample_ready   = NV'($urandom) & NV'($urandom);
         voice_sample         = {$urandom, $urandom};
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/poly_voice_mixer.md
Name: poly_voice_mixer

Overview:
- Parametrised N-voice successor to the fixed three-note chord player. Allocates incoming notes to NUM_VOICES externally instantiated note_player voices and runs a per-voice duration countdown on the 1/48 s beat.
- Steals the voice nearest expiry when all voices are busy.
- Gathers one sample per active voice per codec request and emits a saturated, registered mix with a single-cycle ready pulse.
- Sits between the song/chord sequencer and the codec interface.

Parameters:
NUM_VOICES, 4, number of voices (2..16)
NOTE_W, 6, note code width
DUR_W, 6, duration counter width (beats)
SAMPLE_W, 16, signed per-voice sample width
SUM_W, 18, signed mixed-output width (>= SAMPLE_W)
STEAL_EN, 1, 1 = steal voice when all busy, 0 = drop note

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
play_enable  in  1  high = run; low = freeze counters, ignore loads and sample requests
beat  in  1  1/48 s single-cycle strobe
load_new_note  in  1  single-cycle request to start a note
note_to_load  in  NOTE_W  note code qualified by load_new_note
duration  in  DUR_W  beats qualified by load_new_note
release_all  in  1  synchronous clear of all voices
generate_next_sample  in  1  codec sample request strobe
voice_sample  in  NUM_VOICES*SAMPLE_W  signed samples, voice i at [i*SAMPLE_W +: SAMPLE_W]
voice_sample_ready  in  NUM_VOICES  per-voice sample valid strobe
voice_load  out  NUM_VOICES  one-hot single-cycle load pulse to voice i's note_player
voice_note  out  NUM_VOICES*NOTE_W  registered note per voice
voice_active  out  NUM_VOICES  count_i != 0
note_accepted  out  1  pulse: request was assigned to a voice
note_stolen  out  1  pulse: assignment overwrote an active voice
all_done  out  1  no voice active
final_sample  out  SUM_W  registered signed mix
sample_ready  out  1  single-cycle pulse, final_sample valid

Behaviour:
Reset:
- While reset=0, all registers clear immediately: counts, voice_note, voice_load, note_accepted, note_stolen, final_sample, sample_ready, got flags; FSM to IDLE.
- Therefore all_done=1 and voice_active=0 during reset.

Allocation (evaluated on pre-edge counts):
- Trigger: load_new_note && play_enable && duration != 0. A duration of 0 is ignored with no pulses.
- Target is the lowest-index voice with count == 0.
- If no voice is free and STEAL_EN=1, target is the voice with the smallest count; ties go to the lowest index. note_stolen=1.
- If no voice is free and STEAL_EN=0, the note is dropped and all outputs stay unchanged.
- On the following edge: count_target <= duration, voice_note[target] <= note_to_load, voice_load[target]=1, note_accepted=1. All three pulses last one cycle.
- A voice with count 1 receiving a beat in the same cycle still counts as busy for that allocation.

Counters:
- beat && play_enable: every nonzero count decrements by 1 and saturates at 0.
- Beat coinciding with a load: the target loads the full duration with no decrement; the other voices decrement.
- Priority order: release_all (all counts to 0, no load, no pulses) > load > beat.

Mixer FSM (IDLE, COLLECT, EMIT):
- got_i is set on voice_sample_ready_i in any state, and hold_i captures voice_sample_i on the same edge.
- IDLE: generate_next_sample && play_enable moves to COLLECT.
- COLLECT: when (got_i || !voice_active_i) holds for all i, using this cycle's readies, move to EMIT. Further generate_next_sample strobes are ignored.
- EMIT:
  - Registers final_sample = saturate_SUM_W(sum of sign-extended hold_i over the voices that are active in the COLLECT cycle).
  - sample_ready=1 for one cycle, then the FSM returns to IDLE.
  - All got_i clear on the EMIT->IDLE edge; a ready arriving on that same edge wins over the clear.
- Inactive voices contribute 0. With no voices active, the mix is 0 and sample_ready pulses two cycles after the request.
- Latency: sample_ready is 1 cycle after the last needed ready.
- Saturation clamps to [-2^(SUM_W-1), 2^(SUM_W-1)-1].
- play_enable=0 in COLLECT: the FSM holds and sample_ready cannot assert until play_enable returns.

Test Plan:
1. Reset; load notes 10, 20, 30 (dur 5) on 3 consecutive cycles -> voice_load 0001, 0010, 0100 one cycle after each request; voice_active=0111; voice_note[2]=30; all_done=0.
2. Fill voices with durations 8, 3, 6, 9; load note 40, dur 4 -> voice 1 stolen, note_stolen=1, voice_note[1]=40, count 4. With STEAL_EN=0 -> note_accepted=0 and voices unchanged. A request with duration 0 -> no pulses.
3. Voice 0 loaded with dur 2, then two beats -> voice_active[0] falls on the second beat edge and all_done=1. Beat in the same cycle as a load to a free voice -> that voice's count equals duration. release_all alongside a load -> all counts 0, no voice_load.
4. Voices 0 and 1 active; generate_next_sample; voice 0 ready with 1000, voice 1 ready with -300 three cycles later -> sample_ready one cycle after the second ready, final_sample=700. With no voices active -> sample_ready two cycles after the request, final_sample=0.
5. SUM_W=17 override, four active voices each at 30000 -> final_sample=65535; each at -30000 -> final_sample=-65536.
6. Assert reset low mid-COLLECT with 3 voices active and no clock edge -> voice_active=0, sample_ready=0, final_sample=0 immediately. After release, the first request completes normally.
